// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//    Timing and scan scheduler for a multiplexed display. Two counter-based
//    clock enables are derived from clk:
//       shift_tick  one-cycle pulse every SHIFT_DIV clk cycles
//       scan_tick   one-cycle pulse every SCAN_DIV shift_ticks
//    The single segment bus is time-shared among NUM_DIGITS digits. Each
//    digit slot starts with BLANK_TICKS shift_ticks of blanking, which
//    suppresses ghosting.
//
// Ports
//    clk          system clock
//    rst_n        asynchronous active-low reset
//    enable       run/stop; low clears counters and blanks the display
//    seg_data     digit values, digit i at [i*SEG_W +: SEG_W]
//    shift_tick   shift enable pulse
//    scan_tick    multiplex enable pulse (always coincides with shift_tick)
//    dig_sel      one-hot digit select, zero while blanking
//    seg          latched segment value of the selected digit, zero while blanking
//    frame_start  one-cycle pulse when digit 0 becomes visible
module display_scan_ctrl #(
   parameter int unsigned SHIFT_DIV   = 512,
   parameter int unsigned SCAN_DIV    = 48,
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned BLANK_TICKS = 2,
   parameter int unsigned SEG_W       = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
   output logic                        shift_tick,
   output logic                        scan_tick,
   output logic [NUM_DIGITS-1:0]       dig_sel,
   output logic [SEG_W-1:0]            seg,
   output logic                        frame_start
);

   // Elaboration-time range checks
   if (SHIFT_DIV < 2 || SHIFT_DIV > 65535) begin : g_bad_shift_div
      $error("display_scan_ctrl: SHIFT_DIV out of range 2..65535");
   end
   if (SCAN_DIV < 2 || SCAN_DIV > 255) begin : g_bad_scan_div
      $error("display_scan_ctrl: SCAN_DIV out of range 2..255");
   end
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("display_scan_ctrl: NUM_DIGITS out of range 2..8");
   end
   if (BLANK_TICKS < 1 || BLANK_TICKS > SCAN_DIV - 1) begin : g_bad_blank_ticks
      $error("display_scan_ctrl: BLANK_TICKS out of range 1..SCAN_DIV-1");
   end
   if (SEG_W < 1) begin : g_bad_seg_w
      $error("display_scan_ctrl: SEG_W must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   state_e                  state_q,     state_d;
   logic [15:0]             a_q,         a_d;
   logic [7:0]              b_q,         b_d;
   logic [7:0]              blank_q,     blank_d;
   logic [2:0]              idx_q,       idx_d;
   logic [NUM_DIGITS-1:0]   dig_sel_q,   dig_sel_d;
   logic [SEG_W-1:0]        seg_q,       seg_d;
   logic                    frame_q,     frame_d;

   logic [NUM_DIGITS-1:0]   idx_onehot;
   logic [SEG_W-1:0]        idx_seg;

   // Ticks are combinational from the prescalers so they are gated by enable
   // in the same cycle that enable drops.
   assign shift_tick = enable && (a_q == 16'(SHIFT_DIV - 1));
   assign scan_tick  = shift_tick && (b_q == 8'(SCAN_DIV - 1));

   assign dig_sel     = dig_sel_q;
   assign seg         = seg_q;
   assign frame_start = frame_q;

   // Digit select decode and segment slice mux for the current index
   always_comb begin
      idx_onehot = '0;
      idx_seg    = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            idx_onehot[i] = 1'b1;
            idx_seg       = seg_data[i*SEG_W +: SEG_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      blank_d   = blank_q;
      idx_d     = idx_q;
      dig_sel_d = dig_sel_q;
      seg_d     = seg_q;
      frame_d   = 1'b0;

      if (!enable) begin
         state_d   = IDLE;
         a_d       = '0;
         b_d       = '0;
         blank_d   = '0;
         idx_d     = '0;
         dig_sel_d = '0;
         seg_d     = '0;
      end else begin
         a_d = (a_q == 16'(SHIFT_DIV - 1)) ? '0 : a_q + 16'd1;
         if (shift_tick) begin
            b_d = (b_q == 8'(SCAN_DIV - 1)) ? '0 : b_q + 8'd1;
         end

         case (state_q)
            IDLE: begin
               state_d   = BLANK;
               idx_d     = '0;
               blank_d   = '0;
               dig_sel_d = '0;
               seg_d     = '0;
            end
            BLANK: begin
               dig_sel_d = '0;
               seg_d     = '0;
               if (shift_tick) begin
                  blank_d = blank_q + 8'd1;
                  if (blank_q == 8'(BLANK_TICKS - 1)) begin
                     // Latch the digit once so later seg_data edits cannot tear it
                     state_d   = SHOW;
                     dig_sel_d = idx_onehot;
                     seg_d     = idx_seg;
                     frame_d   = (idx_q == 3'd0);
                  end
               end
            end
            SHOW: begin
               if (scan_tick) begin
                  state_d   = BLANK;
                  blank_d   = '0;
                  idx_d     = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
                  dig_sel_d = '0;
                  seg_d     = '0;
               end
            end
            default: begin
               state_d   = IDLE;
               dig_sel_d = '0;
               seg_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         blank_q   <= '0;
         idx_q     <= '0;
         dig_sel_q <= '0;
         seg_q     <= '0;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         blank_q   <= blank_d;
         idx_q     <= idx_d;
         dig_sel_q <= dig_sel_d;
         seg_q     <= seg_d;
         frame_q   <= frame_d;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with small dividers.
// The reference model only counts consecutive enabled clock edges (m) and
// derives every expected output from that count with plain arithmetic.
module tb_display_scan_ctrl;

   localparam int SHIFT_DIV   = 4;
   localparam int SCAN_DIV    = 8;
   localparam int NUM_DIGITS  = 4;
   localparam int BLANK_TICKS = 2;
   localparam int SEG_W       = 8;
   localparam int SLOT        = SHIFT_DIV * SCAN_DIV;
   localparam int BLANK_CYC   = SHIFT_DIV * BLANK_TICKS;

   logic                        clk;
   logic                        rst_n;
   logic                        enable;
   logic [NUM_DIGITS*SEG_W-1:0] seg_data;
   logic                        shift_tick;
   logic                        scan_tick;
   logic [NUM_DIGITS-1:0]       dig_sel;
   logic [SEG_W-1:0]            seg;
   logic                        frame_start;

   display_scan_ctrl #(
      .SHIFT_DIV   (SHIFT_DIV),
      .SCAN_DIV    (SCAN_DIV),
      .NUM_DIGITS  (NUM_DIGITS),
      .BLANK_TICKS (BLANK_TICKS),
      .SEG_W       (SEG_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .seg_data    (seg_data),
      .shift_tick  (shift_tick),
      .scan_tick   (scan_tick),
      .dig_sel     (dig_sel),
      .seg         (seg),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int               m = 0;       // consecutive enabled edges since stop/reset
   logic [SEG_W-1:0] shown = '0;  // value latched for the visible digit

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m = 0;
      end else if (enable) begin
         m = m + 1;
         if (m >= BLANK_CYC && (m % SLOT) == BLANK_CYC)
            shown = seg_data[((m / SLOT) % NUM_DIGITS)*SEG_W +: SEG_W];
      end else begin
         m = 0;
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      logic                  vis;
      logic [NUM_DIGITS-1:0] exp_sel;
      int                    dig;
      vis     = (m >= BLANK_CYC) && ((m % SLOT) >= BLANK_CYC);
      dig     = (m / SLOT) % NUM_DIGITS;
      exp_sel = '0;
      if (vis) exp_sel[dig] = 1'b1;
      chk("shift_tick", 32'(shift_tick),
          32'(rst_n && enable && ((m + 1) % SHIFT_DIV == 0)));
      chk("scan_tick", 32'(scan_tick),
          32'(rst_n && enable && ((m + 1) % SLOT == 0)));
      chk("dig_sel", 32'(dig_sel), 32'(exp_sel));
      chk("seg", 32'(seg), vis ? 32'(shown) : 32'd0);
      chk("frame_start", 32'(frame_start),
          32'(vis && (m % SLOT) == BLANK_CYC && dig == 0));
   end

   // ---------------- stimulus ----------------
   int cyc;

   task automatic goto_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
         cyc++;
      end
   endtask

   task automatic chk_vis(input string name, input logic [3:0] sel, input logic [7:0] val,
                          input logic fs);
      chk({name, "_sel"},   32'(dig_sel),     32'(sel));
      chk({name, "_seg"},   32'(seg),         32'(val));
      chk({name, "_frame"}, 32'(frame_start), 32'(fs));
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      seg_data = 32'h44332211;
      #12;
      chk_vis("reset", 4'b0000, 8'h00, 1'b0);
      chk("reset_shift", 32'(shift_tick), 32'd0);
      chk("reset_scan",  32'(scan_tick),  32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (100) begin @(posedge clk); #2; end
      chk_vis("idle", 4'b0000, 8'h00, 1'b0);

      // Tick cadence and scan order
      enable = 1'b1; cyc = 1;
      goto_cyc(3);   chk("cyc3_shift", 32'(shift_tick), 32'd0);
      goto_cyc(4);   chk("cyc4_shift", 32'(shift_tick), 32'd1);
      goto_cyc(5);   chk("cyc5_shift", 32'(shift_tick), 32'd0);
      goto_cyc(8);   chk_vis("cyc8", 4'b0000, 8'h00, 1'b0);
      goto_cyc(9);   chk_vis("dig0", 4'b0001, 8'h11, 1'b1);
      goto_cyc(10);  chk_vis("dig0b", 4'b0001, 8'h11, 1'b0);
      goto_cyc(31);  chk("cyc31_scan", 32'(scan_tick), 32'd0);
      goto_cyc(32);  chk("cyc32_scan", 32'(scan_tick), 32'd1);
      goto_cyc(33);  chk_vis("blank1", 4'b0000, 8'h00, 1'b0);
      goto_cyc(40);  chk_vis("blank1e", 4'b0000, 8'h00, 1'b0);
      goto_cyc(41);  chk_vis("dig1", 4'b0010, 8'h22, 1'b0);
      // Coherency: edit digit 1 while it is visible
      goto_cyc(45);  seg_data[15:8] = 8'hAA;
      goto_cyc(64);  chk_vis("dig1_hold", 4'b0010, 8'h22, 1'b0);
      goto_cyc(73);  chk_vis("dig2", 4'b0100, 8'h33, 1'b0);
      goto_cyc(105); chk_vis("dig3", 4'b1000, 8'h44, 1'b0);
      goto_cyc(137); chk_vis("wrap0", 4'b0001, 8'h11, 1'b1);
      goto_cyc(169); chk_vis("dig1_new", 4'b0010, 8'hAA, 1'b0);

      // Stop mid-SHOW of digit 2, then restart
      goto_cyc(210); chk_vis("dig2_b", 4'b0100, 8'h33, 1'b0);
      enable = 1'b0;
      chk("stop_shift", 32'(shift_tick), 32'd0);
      goto_cyc(211); chk_vis("stopped", 4'b0000, 8'h00, 1'b0);
      goto_cyc(216);
      enable = 1'b1; cyc = 1;
      goto_cyc(8);   chk_vis("restart_blank", 4'b0000, 8'h00, 1'b0);
      goto_cyc(9);   chk_vis("restart_dig0", 4'b0001, 8'h11, 1'b1);

      // Asynchronous reset between edges during SHOW
      goto_cyc(20);
      rst_n = 1'b0;
      #1;
      chk_vis("async_rst", 4'b0000, 8'h00, 1'b0);
      chk("async_rst_shift", 32'(shift_tick), 32'd0);
      goto_cyc(22);
      rst_n = 1'b1; cyc = 1;
      goto_cyc(8);   chk_vis("post_rst_blank", 4'b0000, 8'h00, 1'b0);
      goto_cyc(9);   chk_vis("post_rst_dig0", 4'b0001, 8'h11, 1'b1);

      // Randomized phase against the model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if ($urandom_range(15) == 0)
            seg_data[$urandom_range(NUM_DIGITS - 1)*SEG_W +: SEG_W] = 8'($urandom);
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(499) == 0) begin
            rst_n = 1'b0;
         end else if (enable && $urandom_range(199) == 0) begin
            enable = 1'b0;
         end else if (!enable && $urandom_range(9) == 0) begin
            enable = 1'b1;
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
